// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Optional build macro LSU_MISALIGN_TRAP_EN is consumed by load_store_unit.
package lsu_pkg;

  localparam int unsigned DATA_W     = 64;
  localparam int unsigned BYTE_LANES = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_D
  } lsu_size_e;

  // Number of bytes touched by an access of the given size (1, 2, 4 or 8).
  function automatic logic [3:0] size_bytes(input lsu_size_e size);
    return 4'(1) << size;
  endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Byte-lane datapath: builds read-modify-write store data and the
// zero/sign-extended load result from one 8-byte memory window.
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [63:0] rdata,
  input  logic [63:0] wdata,
  output logic [63:0] merged,
  output logic [63:0] load_data
);

  lsu_size_e  sz;
  logic [3:0] nbytes;

  assign sz     = lsu_size_e'(size);
  assign nbytes = size_bytes(sz);

  // Store lanes below the access size come from store data, the rest keep memory contents.
  always_comb begin
    merged = rdata;
    for (int k = 0; k < int'(BYTE_LANES); k++) begin
      if (4'(k) < nbytes) begin
        merged[8*k +: 8] = wdata[8*k +: 8];
      end
    end
  end

  // Load result: low bytes of the window, upper bits zero- or sign-filled.
  always_comb begin
    load_data = rdata;
    case (sz)
      SZ_B:    load_data = {{56{sign & rdata[7]}},  rdata[7:0]};
      SZ_H:    load_data = {{48{sign & rdata[15]}}, rdata[15:0]};
      SZ_W:    load_data = {{32{sign & rdata[31]}}, rdata[31:0]};
      SZ_D:    load_data = rdata;
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, read-modify-write for sub-doubleword
// stores, one response per accepted request.
// Build macro LSU_MISALIGN_TRAP_EN: when defined, misaligned accesses get an
// error response instead of proceeding.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_write,
  input  logic [63:0] mem_rdata
);

  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

  lsu_state_e  state, state_next;

  logic        op_write,  op_write_next;
  lsu_size_e   op_size,   op_size_next;
  logic        op_signed, op_signed_next;
  logic [63:0] op_wdata,  op_wdata_next;

  logic        req_ready_next;
  logic        rsp_valid_next;
  logic [63:0] rsp_rdata_next;
  logic        rsp_err_next;
  logic [63:0] mem_addr_next;
  logic [63:0] mem_wdata_next;
  logic        mem_write_next;

  lsu_size_e   req_size_e;
  logic        accept;
  logic        addr_err;
  logic [63:0] merged_wdata;
  logic [63:0] load_data;

  assign req_size_e = lsu_size_e'(req_size);
  assign accept     = req_valid && req_ready;

  // Reject requests whose 8-byte window leaves memory (and, optionally, misaligned ones).
  always_comb begin
    addr_err = (req_addr > MAX_ADDR);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((req_addr[2:0] & 3'(size_bytes(req_size_e) - 4'd1)) != 3'd0) begin
      addr_err = 1'b1;
    end
`endif
  end

  lsu_lane_merge u_lane_merge (
    .size      (op_size),
    .sign      (op_signed),
    .rdata     (mem_rdata),
    .wdata     (op_wdata),
    .merged    (merged_wdata),
    .load_data (load_data)
  );

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_next     = state;
    op_write_next  = op_write;
    op_size_next   = op_size;
    op_signed_next = op_signed;
    op_wdata_next  = op_wdata;
    req_ready_next = req_ready;
    rsp_valid_next = rsp_valid;
    rsp_rdata_next = rsp_rdata;
    rsp_err_next   = rsp_err;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    mem_write_next = 1'b0;

    case (state)
      IDLE: begin
        req_ready_next = 1'b1;
        if (accept) begin
          req_ready_next = 1'b0;
          op_write_next  = req_write;
          op_size_next   = req_size_e;
          op_signed_next = req_signed;
          op_wdata_next  = req_wdata;
          if (addr_err) begin
            state_next     = RESP;
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
            rsp_rdata_next = '0;
          end else if (req_write && (req_size_e == SZ_D)) begin
            state_next     = WRITE;
            mem_addr_next  = req_addr;
            mem_wdata_next = req_wdata;
            mem_write_next = 1'b1;
          end else begin
            state_next     = READ;
            mem_addr_next  = req_addr;
          end
        end
      end

      READ: begin
        if (op_write) begin
          state_next     = WRITE;
          mem_wdata_next = merged_wdata;
          mem_write_next = 1'b1;
        end else begin
          state_next     = RESP;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b0;
          rsp_rdata_next = load_data;
        end
      end

      WRITE: begin
        state_next     = RESP;
        rsp_valid_next = 1'b1;
        rsp_err_next   = 1'b0;
        rsp_rdata_next = '0;
      end

      RESP: begin
        if (rsp_ready) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b0;
          req_ready_next = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State, latched request fields and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      op_write  <= 1'b0;
      op_size   <= SZ_B;
      op_signed <= 1'b0;
      op_wdata  <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_write <= 1'b0;
    end else begin
      state     <= state_next;
      op_write  <= op_write_next;
      op_size   <= op_size_next;
      op_signed <= op_signed_next;
      op_wdata  <= op_wdata_next;
      req_ready <= req_ready_next;
      rsp_valid <= rsp_valid_next;
      rsp_rdata <= rsp_rdata_next;
      rsp_err   <= rsp_err_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
      mem_write <= mem_write_next;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-array memory and a
// byte-level reference model of loads, stores and error rules.
module tb_load_store_unit;

  localparam int unsigned MEM_BYTES = 1024;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_write;
  logic [63:0] mem_rdata;

  logic [7:0] dmem    [MEM_BYTES];
  logic [7:0] ref_mem [MEM_BYTES];
  int         wr_count = 0;
  int         cyc = 0;
  int         acc_q[$];
  logic       fill = 1'b0;
  logic       bd_we = 1'b0;
  int         bd_addr = 0;
  logic [7:0] bd_data = 8'h00;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Combinational little-endian read port.
  always_comb begin
    mem_rdata = '0;
    if (mem_addr <= 64'(MEM_BYTES - 8)) begin
      for (int k = 0; k < 8; k++) mem_rdata[8*k +: 8] = dmem[int'(mem_addr) + k];
    end
  end

  // Memory writes, backdoor preload, cycle counter and accept log.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst && req_valid && req_ready) acc_q.push_back(cyc);
    if (fill) begin
      for (int i = 0; i < int'(MEM_BYTES); i++) dmem[i] <= 8'(i * 7 + 3);
    end else if (bd_we) begin
      dmem[bd_addr] <= bd_data;
    end
    if (mem_write) begin
      wr_count <= wr_count + 1;
      if (mem_addr <= 64'(MEM_BYTES - 8)) begin
        for (int k = 0; k < 8; k++) dmem[int'(mem_addr) + k] <= mem_wdata[8*k +: 8];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  // Reference model: expected result, error and response latency in cycles after accept.
  function automatic void ref_op(input logic w, input logic [1:0] sz, input logic sg,
                                 input logic [63:0] a, input logic [63:0] wd,
                                 output logic [63:0] rd, output logic er, output int lat);
    int n;
    n  = 1 << sz;
    rd = '0;
    er = (a > 64'(MEM_BYTES - 8));
    if (TRAP && ((a % 64'(n)) != 64'd0)) er = 1'b1;
    if (er) begin
      lat = 1;
    end else if (w) begin
      for (int k = 0; k < n; k++) ref_mem[int'(a) + k] = wd[8*k +: 8];
      lat = (n == 8) ? 2 : 3;
    end else begin
      for (int k = 0; k < n; k++) rd[8*k +: 8] = ref_mem[int'(a) + k];
      if (sg && n < 8 && rd[8*n-1]) begin
        for (int k = n; k < 8; k++) rd[8*k +: 8] = 8'hFF;
      end
      lat = 2;
    end
  endfunction

  function automatic int mem_diff();
    int d;
    d = 0;
    for (int i = 0; i < int'(MEM_BYTES); i++) if (dmem[i] !== ref_mem[i]) d++;
    return d;
  endfunction

  task automatic poke(input int a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // Drive one request, hold the response for 'hold' cycles, then handshake.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [63:0] a, input logic [63:0] wd,
                         input int hold, input bit poke_req,
                         output logic [63:0] rd, output logic er, output int lat,
                         output int wrs, output bit stab, output bit post, output int waitn);
    int wr0;
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    waitn = 0;
    while (!req_ready && waitn < 20) begin @(posedge clk); #1; waitn++; end
    wr0 = wr_count;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    rd = rsp_rdata; er = rsp_err;
    stab = 1'b1;
    if (poke_req) begin
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3;
      req_addr = 64'h60; req_wdata = 64'hDEAD_BEEF_0BAD_F00D;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (!rsp_valid || rsp_rdata !== rd || rsp_err !== er || req_ready) stab = 1'b0;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    post = (rsp_valid === 1'b0) && (req_ready === 1'b1);
    wrs = wr_count - wr0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({req_ready, rsp_valid, rsp_err, mem_write} !== 4'b0) begin errors++;
      $display("FAIL reset_ctrl: got %b required 0000", {req_ready, rsp_valid, rsp_err, mem_write}); end
    checks++; if (rsp_rdata !== 64'd0) begin errors++;
      $display("FAIL reset_rdata: got %h required 0", rsp_rdata); end
    checks++; if (mem_addr !== 64'd0) begin errors++;
      $display("FAIL reset_mem_addr: got %h required 0", mem_addr); end
    checks++; if (mem_wdata !== 64'd0) begin errors++;
      $display("FAIL reset_mem_wdata: got %h required 0", mem_wdata); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++;
      $display("FAIL reset_release_ready: got %b required 1", req_ready); end
  endtask

  task automatic test_load_d();
    logic [63:0] rd, erd; logic er, eer; int lat, elat, wrs, waitn; bit stab, post;
    for (int i = 0; i < 8; i++) poke(i, 8'(i + 1));
    ref_op(1'b0, 2'd3, 1'b0, 64'h0, 64'h0, erd, eer, elat);
    run_req(1'b0, 2'd3, 1'b0, 64'h0, 64'h0, 0, 1'b0, rd, er, lat, wrs, stab, post, waitn);
    checks++; if (rd !== 64'h0807_0605_0403_0201) begin errors++;
      $display("FAIL load_d_data: got %h required 0807060504030201", rd); end
    checks++; if (er !== eer || lat != elat || wrs != 0) begin errors++;
      $display("FAIL load_d_timing: err %b lat %0d writes %0d required %b %0d 0", er, lat, wrs, eer, elat); end
  endtask

  task automatic test_load_byte_sign();
    logic [63:0] rd, erd; logic er, eer; int lat, elat, wrs, waitn; bit stab, post;
    poke(16'h10, 8'h80);
    run_req(1'b0, 2'd0, 1'b1, 64'h10, 64'h0, 0, 1'b0, rd, er, lat, wrs, stab, post, waitn);
    checks++; if (rd !== 64'hFFFF_FFFF_FFFF_FF80 || er !== 1'b0) begin errors++;
      $display("FAIL load_b_signed: got %h err %b required ffffffffffffff80 0", rd, er); end
    run_req(1'b0, 2'd0, 1'b0, 64'h10, 64'h0, 0, 1'b0, rd, er, lat, wrs, stab, post, waitn);
    checks++; if (rd !== 64'h80) begin errors++;
      $display("FAIL load_b_unsigned: got %h required 80", rd); end
    for (int s = 1; s < 3; s++) begin
      for (int sg = 0; sg < 2; sg++) begin
        poke(16'h103, 8'h9C);
        ref_op(1'b0, 2'(s), 1'(sg), 64'h100, 64'h0, erd, eer, elat);
        run_req(1'b0, 2'(s), 1'(sg), 64'h100, 64'h0, 0, 1'b0, rd, er, lat, wrs, stab, post, waitn);
        checks++; if (rd !== erd || er !== eer || lat != elat) begin errors++;
          $display("FAIL load_ext size %0d signed %0d: got %h lat %0d required %h %0d", s, sg, rd, lat, erd, elat); end
      end
    end
  endtask

  task automatic test_store_half();
    logic [63:0] rd, erd, got; logic er, eer; int lat, elat, wrs, waitn; bit stab, post;
    for (int i = 0; i < 8; i++) poke(16'h20 + i, 8'hAA);
    ref_op(1'b1, 2'd1, 1'b0, 64'h20, 64'h1234, erd, eer, elat);
    run_req(1'b1, 2'd1, 1'b0, 64'h20, 64'hFFFF_FFFF_FFFF_1234, 0, 1'b0, rd, er, lat, wrs, stab, post, waitn);
    for (int k = 0; k < 8; k++) got[8*k +: 8] = dmem[16'h20 + k];
    checks++; if (got !== 64'hAAAA_AAAA_AAAA_1234) begin errors++;
      $display("FAIL store_h_mem: got %h required aaaaaaaaaaaa1234", got); end
    checks++; if (wrs != 1 || lat != 3 || er !== 1'b0 || rd !== 64'd0) begin errors++;
      $display("FAIL store_h_rsp: writes %0d lat %0d err %b rdata %h required 1 3 0 0", wrs, lat, er, rd); end
    ref_op(1'b1, 2'd3, 1'b0, 64'h28, 64'h0123_4567_89AB_CDEF, erd, eer, elat);
    run_req(1'b1, 2'd3, 1'b0, 64'h28, 64'h0123_4567_89AB_CDEF, 0, 1'b0, rd, er, lat, wrs, stab, post, waitn);
    checks++; if (wrs != 1 || lat != elat || mem_diff() != 0) begin errors++;
      $display("FAIL store_d: writes %0d lat %0d diffs %0d required 1 %0d 0", wrs, lat, mem_diff(), elat); end
  endtask

  task automatic test_range_err();
    logic [63:0] rd, erd; logic er, eer; int lat, elat, wrs, waitn; bit stab, post;
    run_req(1'b0, 2'd0, 1'b0, 64'(MEM_BYTES - 7), 64'h0, 0, 1'b0, rd, er, lat, wrs, stab, post, waitn);
    checks++; if (er !== 1'b1 || rd !== 64'd0 || lat != 1 || wrs != 0) begin errors++;
      $display("FAIL range_load: err %b rdata %h lat %0d writes %0d required 1 0 1 0", er, rd, lat, wrs); end
    run_req(1'b1, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h55, 0, 1'b0, rd, er, lat, wrs, stab, post, waitn);
    checks++; if (er !== 1'b1 || wrs != 0 || mem_diff() != 0) begin errors++;
      $display("FAIL range_store: err %b writes %0d diffs %0d required 1 0 0", er, wrs, mem_diff()); end
    ref_op(1'b0, 2'd3, 1'b0, 64'(MEM_BYTES - 8), 64'h0, erd, eer, elat);
    run_req(1'b0, 2'd3, 1'b0, 64'(MEM_BYTES - 8), 64'h0, 0, 1'b0, rd, er, lat, wrs, stab, post, waitn);
    checks++; if (er !== 1'b0 || rd !== erd) begin errors++;
      $display("FAIL range_last_window: err %b rdata %h required 0 %h", er, rd, erd); end
  endtask

  task automatic test_misalign();
    logic [63:0] rd, erd; logic er, eer; int lat, elat, wrs, waitn; bit stab, post;
    ref_op(1'b0, 2'd2, 1'b0, 64'h3, 64'h0, erd, eer, elat);
    run_req(1'b0, 2'd2, 1'b0, 64'h3, 64'h0, 0, 1'b0, rd, er, lat, wrs, stab, post, waitn);
    checks++; if (er !== TRAP || rd !== erd || lat != elat) begin errors++;
      $display("FAIL misalign_load: err %b rdata %h lat %0d required %b %h %0d", er, rd, lat, TRAP, erd, elat); end
    ref_op(1'b1, 2'd3, 1'b0, 64'h51, 64'hCAFE_F00D_1234_5678, erd, eer, elat);
    run_req(1'b1, 2'd3, 1'b0, 64'h51, 64'hCAFE_F00D_1234_5678, 0, 1'b0, rd, er, lat, wrs, stab, post, waitn);
    checks++; if (er !== TRAP || wrs != (TRAP ? 0 : 1) || mem_diff() != 0) begin errors++;
      $display("FAIL misalign_store: err %b writes %0d diffs %0d required %b %0d 0", er, wrs, mem_diff(), TRAP, TRAP ? 0 : 1); end
  endtask

  task automatic test_backpressure();
    logic [63:0] rd, erd; logic er, eer; int lat, elat, wrs, waitn, n0; bit stab, post;
    n0 = acc_q.size();
    ref_op(1'b0, 2'd3, 1'b0, 64'h8, 64'h0, erd, eer, elat);
    run_req(1'b0, 2'd3, 1'b0, 64'h8, 64'h0, 5, 1'b1, rd, er, lat, wrs, stab, post, waitn);
    checks++; if (!stab || rd !== erd) begin errors++;
      $display("FAIL hold_stable: stable %0d rdata %h required 1 %h", stab, rd, erd); end
    checks++; if (acc_q.size() - n0 != 1 || wrs != 0 || mem_diff() != 0) begin errors++;
      $display("FAIL hold_ignore_req: accepts %0d writes %0d diffs %0d required 1 0 0", acc_q.size() - n0, wrs, mem_diff()); end
    checks++; if (!post) begin errors++;
      $display("FAIL hold_release: rsp_valid %b req_ready %b required 0 1", rsp_valid, req_ready); end
    ref_op(1'b0, 2'd1, 1'b1, 64'hA, 64'h0, erd, eer, elat);
    run_req(1'b0, 2'd1, 1'b1, 64'hA, 64'h0, 0, 1'b0, rd, er, lat, wrs, stab, post, waitn);
    checks++; if (waitn != 0 || rd !== erd) begin errors++;
      $display("FAIL next_accept: wait %0d rdata %h required 0 %h", waitn, rd, erd); end
  endtask

  task automatic test_reset_abort();
    int wr0, n, seen;
    poke(16'h30, 8'h5A);
    wr0 = wr_count;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 64'h30; req_wdata = 64'hC3;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if ({req_ready, rsp_valid, rsp_err, mem_write} !== 4'b0 || rsp_rdata !== 64'd0 ||
                  mem_addr !== 64'd0 || mem_wdata !== 64'd0) begin errors++;
      $display("FAIL abort_outputs: ctrl %b rdata %h addr %h wdata %h required 0", {req_ready, rsp_valid, rsp_err, mem_write}, rsp_rdata, mem_addr, mem_wdata); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (rsp_valid) seen++; end
    checks++; if (seen != 0 || wr_count != wr0 || dmem[16'h30] !== 8'h5A) begin errors++;
      $display("FAIL abort_no_effect: rsp cycles %0d writes %0d byte %h required 0 0 5a", seen, wr_count - wr0, dmem[16'h30]); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] erd; logic eer; int elat, n0, t;
    logic       ws [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [1:0] ss [5] = '{2'd3, 2'd0, 2'd3, 2'd0, 2'd2};
    logic [63:0] as [5] = '{64'h40, 64'h41, 64'h48, 64'(MEM_BYTES), 64'h44};
    int         gap [4] = '{3, 4, 3, 2};
    rsp_ready = 1'b1;
    n0 = acc_q.size();
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_write = ws[i]; req_size = ss[i]; req_signed = 1'b0;
      req_addr = as[i]; req_wdata = 64'(i) * 64'h0101_0101_0101_0101 + 64'h11;
      ref_op(ws[i], ss[i], 1'b0, as[i], req_wdata, erd, eer, elat);
      t = 0;
      while (acc_q.size() == n0 + i && t < 30) begin @(posedge clk); #1; t++; end
    end
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checks++; if (acc_q.size() - n0 != 5) begin errors++;
      $display("FAIL b2b_accepts: got %0d required 5", acc_q.size() - n0); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (acc_q[n0 + i + 1] - acc_q[n0 + i] != gap[i]) begin errors++;
          $display("FAIL b2b_gap %0d: got %0d required %0d", i, acc_q[n0 + i + 1] - acc_q[n0 + i], gap[i]); end
      end
    end
    checks++; if (mem_diff() != 0 || rsp_valid !== 1'b0) begin errors++;
      $display("FAIL b2b_mem: diffs %0d rsp_valid %b required 0 0", mem_diff(), rsp_valid); end
  endtask

  task automatic test_random();
    logic [63:0] rd, erd, a, wd; logic er, eer, w, sg; logic [1:0] sz;
    int lat, elat, wrs, waitn, hold; bit stab, post;
    for (int it = 0; it < 40; it++) begin
      w    = 1'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      sg   = 1'($urandom_range(0, 1));
      a    = 64'($urandom_range(0, MEM_BYTES - 1));
      wd   = {32'($urandom), 32'($urandom)};
      hold = $urandom_range(0, 2);
      ref_op(w, sz, sg, a, wd, erd, eer, elat);
      run_req(w, sz, sg, a, wd, hold, 1'b0, rd, er, lat, wrs, stab, post, waitn);
      checks++;
      if (rd !== erd || er !== eer || lat != elat || wrs != ((w && !eer) ? 1 : 0) || !stab || !post) begin
        errors++;
        $display("FAIL random %0d w%b sz%0d sg%b a=%h: rdata %h err %b lat %0d wr %0d stab %0d post %0d required %h %b %0d %0d 1 1",
                 it, w, sz, sg, a, rd, er, lat, wrs, stab, post, erd, eer, elat, (w && !eer) ? 1 : 0);
      end
    end
    checks++; if (mem_diff() != 0) begin errors++;
      $display("FAIL random_mem: %0d differing bytes required 0", mem_diff()); end
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    fill = 1'b1;
    @(posedge clk); #1;
    fill = 1'b0;
    for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = 8'(i * 7 + 3);
    test_reset();
    test_load_d();
    test_load_byte_sign();
    test_store_half();
    test_range_err();
    test_misalign();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
